// File: rtl/ua_pkg.sv
// Shared constants and types for the unary accumulator scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package ua_pkg;

  localparam int UA_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    RESP
  } ua_state_e;

endpackage

// File: rtl/ua_rr_arb.sv
// Round-robin grant: first valid index at or after the pointer, wrapping.
// Purely combinational; the caller owns and advances the pointer.
module ua_rr_arb
  import ua_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            any_o
);

  logic found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid_i[(int'(ptr_i) + i) % NREQ]) begin
        found = 1'b1;
        gnt_o[(int'(ptr_i) + i) % NREQ] = 1'b1;
        gnt_id_o = ID_W'((int'(ptr_i) + i) % NREQ);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/unary_add_sched.sv
// Shares one unary accumulator among NREQ requesters: feed a,b, drain, respond.
// Optional UA_SCHED_STATS_EN adds saturating job / overflow counters.
module unary_add_sched
  import ua_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = UA_W,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ID_W-1:0]   resp_id,
  output logic [W-1:0]      resp_sum,
  output logic              resp_carry,
  output logic              busy,
`ifdef UA_SCHED_STATS_EN
  output logic [15:0]       stat_jobs,
  output logic [15:0]       stat_ovf,
`endif
  output logic              ua_en,
  output logic              ua_rw,
  output logic              ua_a,
  output logic              ua_b,
  input  logic              ua_dout,
  input  logic              ua_c
);

  ua_state_e       state_q;
  logic [W-1:0]    a_rem_q;
  logic [W-1:0]    b_rem_q;
  logic [ID_W-1:0] id_q;
  logic [W-1:0]    res_q;
  logic            carry_q;
  logic [ID_W-1:0] ptr_q;
  logic            first_q;

  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic            any;
  logic [ID_W-1:0] ptr_d;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;

  ua_rr_arb #(
    .NREQ(NREQ),
    .ID_W(ID_W)
  ) u_arb (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .gnt_id_o(gnt_id),
    .any_o   (any)
  );

  always_comb begin
    a_sel = req_a[int'(gnt_id)*W +: W];
    b_sel = req_b[int'(gnt_id)*W +: W];
    ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + ID_W'(1);
  end

  assign req_ready  = (state_q == IDLE) ? gnt : '0;
  assign busy       = (state_q != IDLE);
  assign ua_en      = (state_q == FEED) || (state_q == DRAIN);
  assign ua_rw      = (state_q == DRAIN);
  assign ua_a       = (state_q == FEED) && (a_rem_q != '0);
  assign ua_b       = (state_q == FEED) && (b_rem_q != '0);
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_sum   = res_q;
  assign resp_carry = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_rem_q <= '0;
      b_rem_q <= '0;
      id_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ptr_q   <= '0;
      first_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any) begin
            a_rem_q <= a_sel;
            b_rem_q <= b_sel;
            id_q    <= gnt_id;
            res_q   <= '0;
            carry_q <= 1'b0;
            ptr_q   <= ptr_d;
            first_q <= 1'b1;
            if (a_sel == '0 && b_sel == '0)
              state_q <= DRAIN;
            else
              state_q <= FEED;
          end
        end
        FEED: begin
          carry_q <= carry_q | ua_c;
          if (a_rem_q != '0)
            a_rem_q <= a_rem_q - W'(1);
          if (b_rem_q != '0)
            b_rem_q <= b_rem_q - W'(1);
          if (a_rem_q <= W'(1) && b_rem_q <= W'(1))
            state_q <= DRAIN;
        end
        DRAIN: begin
          // dout is registered: cycle 0 still shows the idle 0
          carry_q <= carry_q | ua_c;
          res_q   <= res_q + W'(ua_dout);
          first_q <= 1'b0;
          if (!first_q && !ua_dout)
            state_q <= RESP;
        end
        RESP: begin
          if (resp_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UA_SCHED_STATS_EN
  logic [15:0] jobs_q;
  logic [15:0] ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jobs_q <= '0;
      ovf_q  <= '0;
    end else if (resp_valid && resp_ready) begin
      if (jobs_q != 16'hFFFF)
        jobs_q <= jobs_q + 16'd1;
      if (carry_q && ovf_q != 16'hFFFF)
        ovf_q <= ovf_q + 16'd1;
    end
  end

  assign stat_jobs = jobs_q;
  assign stat_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_unary_add_sched.sv
// Scoreboard bench for unary_add_sched with a behavioural unary accumulator.
module tb_unary_add_sched;

  localparam int NREQ = 2;
  localparam int W    = 7;
  localparam int ID_W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [ID_W-1:0]   resp_id;
  logic [W-1:0]      resp_sum;
  logic              resp_carry;
  logic              busy;
  logic              ua_en, ua_rw, ua_a, ua_b;
  logic              ua_dout, ua_c;
`ifdef UA_SCHED_STATS_EN
  logic [15:0]       stat_jobs, stat_ovf;
`endif

  unary_add_sched #(.NREQ(NREQ), .W(W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_sum  (resp_sum),
    .resp_carry(resp_carry),
    .busy      (busy),
`ifdef UA_SCHED_STATS_EN
    .stat_jobs (stat_jobs),
    .stat_ovf  (stat_ovf),
`endif
    .ua_en     (ua_en),
    .ua_rw     (ua_rw),
    .ua_a      (ua_a),
    .ua_b      (ua_b),
    .ua_dout   (ua_dout),
    .ua_c      (ua_c)
  );

  // Unary accumulator: read adds pulses, write emits one pulse per count
  logic [W-1:0] m_cnt;
  logic [W:0]   m_sum;
  assign m_sum = {1'b0, m_cnt} + {{W{1'b0}}, ua_a} + {{W{1'b0}}, ua_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= '0;
      ua_dout <= 1'b0;
      ua_c    <= 1'b0;
    end else if (!ua_en) begin
      ua_dout <= 1'b0;
    end else if (!ua_rw) begin
      m_cnt   <= m_sum[W-1:0];
      ua_c    <= m_sum[W];
      ua_dout <= 1'b0;
    end else begin
      ua_dout <= (m_cnt != '0);
      if (m_cnt != '0) m_cnt <= m_cnt - 7'd1;
      ua_c    <= 1'b0;
    end
  end

  typedef struct {
    int         id;
    logic [W-1:0] sum;
    logic       carry;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   feed_n = 0, drain_n = 0;
  int   last_lat = -1, last_feed = -1, last_drain = -1;
  int   resp_cnt = 0;
  logic rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    int   s;
    if (!rst_n) begin
      rv_prev = 1'b0;
    end else begin
      if (ua_en && !ua_rw) feed_n++;
      if (ua_en && ua_rw) drain_n++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          s = int'(req_a[i*W +: W]) + int'(req_b[i*W +: W]);
          e.id = i;
          e.sum = W'(s);
          e.carry = (s >= 128);
          e.t = cyc;
          exp_q.push_back(e);
          grant_log.push_back(i);
          feed_n = 0;
          drain_n = 0;
        end
      end
      if (resp_valid && !rv_prev) begin
        last_feed = feed_n;
        last_drain = drain_n;
        last_lat = (exp_q.size() != 0) ? cyc - exp_q[0].t : -1;
      end
      if (resp_valid && resp_ready) begin
        resp_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected got id=%0d sum=%0d want none",
                   resp_id, resp_sum);
        end else begin
          e = exp_q.pop_front();
          if ({resp_id, resp_sum, resp_carry} !== {ID_W'(e.id), e.sum, e.carry}) begin
            errors++;
            $display("FAIL resp_data got id=%0d sum=%0d c=%0d want id=%0d sum=%0d c=%0d",
                     resp_id, resp_sum, resp_carry, e.id, e.sum, e.carry);
          end
        end
      end
      rv_prev = resp_valid;
    end
  end

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(posedge clk); #1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[id] && n < 500);
    if (!req_ready[id]) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout id=%0d got ready=0 want 1", id);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got pending=%0d want 0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({resp_valid, req_ready, busy, ua_en, ua_rw, ua_a, ua_b,
         resp_id, resp_sum, resp_carry} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rv=%0b rdy=%0b busy=%0b en=%0b sum=%0d want all 0",
               resp_valid, req_ready, busy, ua_en, resp_sum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    issue(0, 7'd3, 7'd4);
    wait_idle("basic");
    checks++;
    if (last_lat !== 14) begin
      errors++;
      $display("FAIL basic_latency got %0d want 14", last_lat);
    end
    checks++;
    if (last_feed !== 4) begin
      errors++;
      $display("FAIL basic_feed got %0d want 4", last_feed);
    end
    checks++;
    if (last_drain !== 9) begin
      errors++;
      $display("FAIL basic_drain got %0d want 9", last_drain);
    end
  endtask

  task automatic test_overflow();
    issue(0, 7'd100, 7'd100);
    wait_idle("ovf100");
    checks++;
    if (last_lat !== 175) begin
      errors++;
      $display("FAIL ovf100_latency got %0d want 175", last_lat);
    end
    issue(1, 7'd127, 7'd127);
    wait_idle("ovf127");
    checks++;
    if (last_feed !== 127 || last_drain !== 128) begin
      errors++;
      $display("FAIL ovf127_phases got feed=%0d drain=%0d want 127 128",
               last_feed, last_drain);
    end
    checks++;
    if (last_lat !== 256) begin
      errors++;
      $display("FAIL ovf127_latency got %0d want 256", last_lat);
    end
  endtask

  task automatic test_zero();
    issue(0, 7'd0, 7'd0);
    wait_idle("zero");
    checks++;
    if (last_lat !== 3) begin
      errors++;
      $display("FAIL zero_latency got %0d want 3", last_lat);
    end
    checks++;
    if (last_feed !== 0 || last_drain !== 2) begin
      errors++;
      $display("FAIL zero_phases got feed=%0d drain=%0d want 0 2",
               last_feed, last_drain);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int n;
    issue(1, 7'd1, 7'd1);
    wait_idle("b2b_pre");
    @(posedge clk); #1;
    req_a = {7'd2, 7'd5};
    req_b = {7'd9, 7'd1};
    req_valid = 2'b11;
    base = grant_log.size();
    n = 0;
    while (grant_log.size() < base + 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle("b2b");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (grant_log.size() <= base + i) begin
        errors++;
        $display("FAIL b2b_grant%0d got none want %0d", i, i % 2);
      end else if (grant_log[base+i] != i % 2) begin
        errors++;
        $display("FAIL b2b_grant%0d got %0d want %0d", i, grant_log[base+i], i % 2);
      end
    end
  endtask

  task automatic test_hold();
    int n;
    int bad;
    resp_ready = 1'b0;
    issue(0, 7'd9, 7'd8);
    req_a[W +: W] = 7'd3;
    req_b[W +: W] = 7'd3;
    req_valid[1] = 1'b1;
    n = 0;
    while (!resp_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_sum !== 7'd17 || resp_id !== 1'b0 ||
          resp_carry !== 1'b0 || req_ready !== '0 || ua_en !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable got %0d bad cycles want 0", bad);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[1] && n < 500);
    checks++;
    if (!req_ready[1]) begin
      errors++;
      $display("FAIL hold_next_grant got 0 want 1");
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle("hold");
  endtask

  task automatic test_reset_mid();
    int n;
    int rc;
    issue(0, 7'd50, 7'd40);
    n = 0;
    while (!(ua_en && ua_rw) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({resp_valid, req_ready, busy, ua_en, ua_rw, ua_a, ua_b,
         resp_id, resp_sum, resp_carry} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got rv=%0b busy=%0b en=%0b sum=%0d want all 0",
               resp_valid, busy, ua_en, resp_sum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rc = resp_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (resp_cnt != rc || resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet got resps=%0d rv=%0b busy=%0b want 0 0 0",
               resp_cnt - rc, resp_valid, busy);
    end
    issue(1, 7'd5, 7'd6);
    wait_idle("after_reset");
    checks++;
    if (last_feed !== 6 || last_drain !== 13) begin
      errors++;
      $display("FAIL after_reset_phases got feed=%0d drain=%0d want 6 13",
               last_feed, last_drain);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
